// File: rtl/wshb_arbiter2.sv
// wshb_arbiter2: two-master, one-slave Wishbone arbiter for the SDRAM port.
// Master 0 is the video-stream reader, master 1 the frame-buffer writer.
// Round-robin on cyc; a grant is held for the whole bus cycle, so a burst
// is never preempted. Also counts acks delivered to each master for debug.
module wshb_arbiter2 #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic              m0_cyc,
    input  logic              m0_stb,
    input  logic              m0_we,
    input  logic [AW-1:0]     m0_adr,
    input  logic [DW-1:0]     m0_dat_ms,
    input  logic [DW/8-1:0]   m0_sel,
    input  logic [2:0]        m0_cti,
    input  logic [1:0]        m0_bte,
    output logic [DW-1:0]     m0_dat_sm,
    output logic              m0_ack,
    output logic              m0_err,
    output logic              m0_rty,

    input  logic              m1_cyc,
    input  logic              m1_stb,
    input  logic              m1_we,
    input  logic [AW-1:0]     m1_adr,
    input  logic [DW-1:0]     m1_dat_ms,
    input  logic [DW/8-1:0]   m1_sel,
    input  logic [2:0]        m1_cti,
    input  logic [1:0]        m1_bte,
    output logic [DW-1:0]     m1_dat_sm,
    output logic              m1_ack,
    output logic              m1_err,
    output logic              m1_rty,

    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [AW-1:0]     s_adr,
    output logic [DW-1:0]     s_dat_ms,
    output logic [DW/8-1:0]   s_sel,
    output logic [2:0]        s_cti,
    output logic [1:0]        s_bte,
    input  logic [DW-1:0]     s_dat_sm,
    input  logic              s_ack,
    input  logic              s_err,
    input  logic              s_rty,

    output logic [1:0]        gnt,
    output logic [CW-1:0]     ack_cnt0,
    output logic [CW-1:0]     ack_cnt1
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       last;
    logic       sel0;
    logic       sel1;

    assign sel0 = (state == ST_GNT0);
    assign sel1 = (state == ST_GNT1);

    // Next grant: only re-arbitrate once the owning master has dropped cyc,
    // handing straight over to a waiting master with no idle cycle between.
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (m0_cyc && m1_cyc)
                    next_state = last ? ST_GNT0 : ST_GNT1;
                else if (m0_cyc)
                    next_state = ST_GNT0;
                else if (m1_cyc)
                    next_state = ST_GNT1;
                else
                    next_state = ST_IDLE;
            end
            ST_GNT0: begin
                if (m0_cyc)
                    next_state = ST_GNT0;
                else if (m1_cyc)
                    next_state = ST_GNT1;
                else
                    next_state = ST_IDLE;
            end
            ST_GNT1: begin
                if (m1_cyc)
                    next_state = ST_GNT1;
                else if (m0_cyc)
                    next_state = ST_GNT0;
                else
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Grant state and round-robin memory; last starts at 1 so master 0 wins the first tie.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            state <= next_state;
            if (next_state == ST_GNT0)
                last <= 1'b0;
            else if (next_state == ST_GNT1)
                last <= 1'b1;
        end
    end

    // Request mux: forward the granted master; when idle the control strobes
    // are forced low and the remaining fields simply come from master 0.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        if (sel0) begin
            s_cyc = m0_cyc;
            s_stb = m0_stb & m0_cyc;
            s_we  = m0_we;
        end else if (sel1) begin
            s_cyc    = m1_cyc;
            s_stb    = m1_stb & m1_cyc;
            s_we     = m1_we;
            s_adr    = m1_adr;
            s_dat_ms = m1_dat_ms;
            s_sel    = m1_sel;
            s_cti    = m1_cti;
            s_bte    = m1_bte;
        end
    end

    // Response path is pure combinational gating so no latency is added;
    // read data fans out to both masters since only the granted one sees ack.
    always_comb begin
        m0_dat_sm = s_dat_sm;
        m1_dat_sm = s_dat_sm;
        m0_ack    = s_ack & sel0;
        m0_err    = s_err & sel0;
        m0_rty    = s_rty & sel0;
        m1_ack    = s_ack & sel1;
        m1_err    = s_err & sel1;
        m1_rty    = s_rty & sel1;
    end

    assign gnt = {sel1, sel0};

    // Debug counters of acks delivered to each master, wrapping naturally.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ack_cnt0 <= '0;
            ack_cnt1 <= '0;
        end else begin
            if (m0_ack)
                ack_cnt0 <= ack_cnt0 + 1'b1;
            if (m1_ack)
                ack_cnt1 <= ack_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_wshb_arbiter2.sv
// tb_wshb_arbiter2: directed vector table for the grant FSM and routing,
// followed by hand-written multi-cycle sequences (single reads, ties,
// long burst, counter wrap, reset during a burst).
module tb_wshb_arbiter2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;

    logic              m0_cyc, m0_stb, m0_we;
    logic [AW-1:0]     m0_adr;
    logic [DW-1:0]     m0_dat_ms;
    logic [DW/8-1:0]   m0_sel;
    logic [2:0]        m0_cti;
    logic [1:0]        m0_bte;
    logic [DW-1:0]     m0_dat_sm;
    logic              m0_ack, m0_err, m0_rty;

    logic              m1_cyc, m1_stb, m1_we;
    logic [AW-1:0]     m1_adr;
    logic [DW-1:0]     m1_dat_ms;
    logic [DW/8-1:0]   m1_sel;
    logic [2:0]        m1_cti;
    logic [1:0]        m1_bte;
    logic [DW-1:0]     m1_dat_sm;
    logic              m1_ack, m1_err, m1_rty;

    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_ms;
    logic [DW/8-1:0]   s_sel;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;
    logic [1:0]        gnt;
    logic [CW-1:0]     ack_cnt0, ack_cnt1;

    logic              slave_en;
    logic              man_ack, man_err;
    logic [DW-1:0]     man_dat;
    logic              auto_ack, ack_next;
    logic [DW-1:0]     auto_dat, dat_next;
    logic              s_ack_w;
    logic [DW-1:0]     s_dat_w;

    int checks = 0;
    int failures = 0;

    assign s_ack_w = slave_en ? auto_ack : man_ack;
    assign s_dat_w = slave_en ? auto_dat : man_dat;

    wshb_arbiter2 #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
        .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
        .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_dat_sm(s_dat_w), .s_ack(s_ack_w), .s_err(man_err), .s_rty(man_err),
        .gnt(gnt), .ack_cnt0(ack_cnt0), .ack_cnt1(ack_cnt1)
    );

    always #5 sys_clk = ~sys_clk;

    // Simple slave: acks one cycle after it sees stb, returning the address as data.
    always @(negedge sys_clk) begin
        ack_next = !sys_rst && s_cyc && s_stb && !s_ack_w;
        dat_next = s_adr;
    end

    always @(posedge sys_clk) begin
        #1;
        auto_ack = sys_rst ? 1'b0 : ack_next;
        auto_dat = dat_next;
    end

    typedef struct {
        logic       rst;
        logic       m0c, m0s, m0w;
        logic       m1c, m1s, m1w;
        logic       ack, err;
        logic [1:0] gnt;
        logic       scyc, sstb, swe;
        logic [7:0] sadr;
        logic       m0ack, m1ack, m0err, m1err;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic [8:0] in_bits, input logic [1:0] g,
                                input logic [2:0] cse, input logic [7:0] a,
                                input logic [3:0] resp);
        vec_t v;
        {v.rst, v.m0c, v.m0s, v.m0w, v.m1c, v.m1s, v.m1w, v.ack, v.err} = in_bits;
        v.gnt = g;
        {v.scyc, v.sstb, v.swe} = cse;
        v.sadr = a;
        {v.m0ack, v.m1ack, v.m0err, v.m1err} = resp;
        return v;
    endfunction

    task automatic tick;
        @(posedge sys_clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        sys_rst = v.rst;
        m0_cyc = v.m0c; m0_stb = v.m0s; m0_we = v.m0w; m0_adr = 32'h10;
        m1_cyc = v.m1c; m1_stb = v.m1s; m1_we = v.m1w; m1_adr = 32'h20;
        man_ack = v.ack;
        man_err = v.err;
    endtask

    task automatic clear_masters;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_cti = 3'b000;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_cti = 3'b000;
    endtask

    task automatic do_reset;
        sys_rst = 1'b1;
        clear_masters();
        tick();
        tick();
        sys_rst = 1'b0;
        tick();
    endtask

    // One classic single read from master 0, waiting a bounded number of cycles for ack.
    task automatic m0_read(input string tag, input logic [31:0] adr, input bit chk_gnt, inout bit m1_seen);
        bit got;
        got = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = adr;
        tick();
        if (chk_gnt)
            checkOutput({tag, "_gnt_latency"}, 32'(gnt), 32'h1);
        for (int k = 0; k < 20 && !got; k++) begin
            if (m1_ack) m1_seen = 1'b1;
            if (m0_ack) begin
                got = 1'b1;
                checkOutput({tag, "_m0_dat"}, m0_dat_sm, adr);
                checkOutput({tag, "_m1_dat_fanout"}, m1_dat_sm, adr);
            end else begin
                tick();
            end
        end
        checkOutput({tag, "_ack_seen"}, 32'(got), 32'h1);
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
    endtask

    initial begin
        bit   m1_seen;
        bit   got;
        int   n;
        int   beats;
        bit   bad_gnt;
        bit   bad_ack;

        slave_en = 1'b0; man_ack = 1'b0; man_err = 1'b0; man_dat = '0;
        auto_ack = 1'b0; auto_dat = '0; ack_next = 1'b0; dat_next = '0;
        clear_masters();
        m0_dat_ms = 32'h0A0A0A0A; m1_dat_ms = 32'h1B1B1B1B;
        m0_sel = 4'hF; m1_sel = 4'h3; m0_bte = 2'b00; m1_bte = 2'b01;

        // Bits: {rst, m0 cyc/stb/we, m1 cyc/stb/we, ack, err}; resp: {m0ack, m1ack, m0err, m1err}
        vecs[0]  = mk(9'b1_000_000_00, 2'b00, 3'b000, 8'h10, 4'b0000);
        vecs[1]  = mk(9'b0_000_000_00, 2'b00, 3'b000, 8'h10, 4'b0000);
        vecs[2]  = mk(9'b0_111_110_11, 2'b00, 3'b000, 8'h10, 4'b0000);
        vecs[3]  = mk(9'b0_111_110_00, 2'b01, 3'b111, 8'h10, 4'b0000);
        vecs[4]  = mk(9'b0_111_110_10, 2'b01, 3'b111, 8'h10, 4'b1000);
        vecs[5]  = mk(9'b0_000_110_00, 2'b01, 3'b000, 8'h10, 4'b0000);
        vecs[6]  = mk(9'b0_000_110_00, 2'b10, 3'b110, 8'h20, 4'b0000);
        vecs[7]  = mk(9'b0_000_110_11, 2'b10, 3'b110, 8'h20, 4'b0101);
        vecs[8]  = mk(9'b0_110_000_00, 2'b10, 3'b000, 8'h20, 4'b0000);
        vecs[9]  = mk(9'b0_110_000_00, 2'b01, 3'b110, 8'h10, 4'b0000);
        vecs[10] = mk(9'b0_000_000_00, 2'b01, 3'b000, 8'h10, 4'b0000);
        vecs[11] = mk(9'b0_110_110_00, 2'b00, 3'b000, 8'h10, 4'b0000);
        vecs[12] = mk(9'b0_110_110_00, 2'b10, 3'b110, 8'h20, 4'b0000);
        vecs[13] = mk(9'b0_110_000_00, 2'b10, 3'b000, 8'h20, 4'b0000);
        vecs[14] = mk(9'b0_100_000_10, 2'b01, 3'b100, 8'h10, 4'b1000);
        vecs[15] = mk(9'b0_000_000_00, 2'b01, 3'b000, 8'h10, 4'b0000);
        vecs[16] = mk(9'b0_000_000_00, 2'b00, 3'b000, 8'h10, 4'b0000);

        $display("[TB] vector table");
        tick();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            checkOutput($sformatf("v%0d_s_cyc", i), 32'(s_cyc), 32'(vecs[i].scyc));
            checkOutput($sformatf("v%0d_s_stb", i), 32'(s_stb), 32'(vecs[i].sstb));
            checkOutput($sformatf("v%0d_s_we", i), 32'(s_we), 32'(vecs[i].swe));
            checkOutput($sformatf("v%0d_s_adr", i), s_adr, 32'(vecs[i].sadr));
            checkOutput($sformatf("v%0d_m0_ack", i), 32'(m0_ack), 32'(vecs[i].m0ack));
            checkOutput($sformatf("v%0d_m1_ack", i), 32'(m1_ack), 32'(vecs[i].m1ack));
            checkOutput($sformatf("v%0d_m0_err", i), 32'(m0_err), 32'(vecs[i].m0err));
            checkOutput($sformatf("v%0d_m1_rty", i), 32'(m1_rty), 32'(vecs[i].m1err));
            if (i == 0) begin
                checkOutput("v0_ack_cnt0", 32'(ack_cnt0), 32'h0);
                checkOutput("v0_ack_cnt1", 32'(ack_cnt1), 32'h0);
            end
            tick();
        end
        checkOutput("table_ack_cnt0", 32'(ack_cnt0), 32'h2);
        checkOutput("table_ack_cnt1", 32'(ack_cnt1), 32'h1);
        man_ack = 1'b0; man_err = 1'b0;

        // Single master: 8 reads from m0 with the auto slave.
        $display("[TB] single master reads");
        slave_en = 1'b1;
        do_reset();
        checkOutput("t1_gnt_idle", 32'(gnt), 32'h0);
        checkOutput("t1_s_cyc_idle", 32'(s_cyc), 32'h0);
        m1_seen = 1'b0;
        for (int i = 0; i < 8; i++)
            m0_read($sformatf("t2_rd%0d", i), 32'h100 + 32'(i) * 4, 1'b1, m1_seen);
        checkOutput("t2_ack_cnt0", 32'(ack_cnt0), 32'h8);
        checkOutput("t2_m1_ack_never", 32'(m1_seen), 32'h0);

        // Tie from reset goes to m0; handover; second tie goes back to m0.
        $display("[TB] tie and alternation");
        do_reset();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h40;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h80;
        tick();
        checkOutput("t3_tie1_gnt", 32'(gnt), 32'h1);
        n = 0; m1_seen = 1'b0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            if (m1_ack) m1_seen = 1'b1;
            if (m0_ack) n++;
            if (n < 4) tick();
        end
        checkOutput("t3_m0_acks", 32'(n), 32'h4);
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        tick();
        checkOutput("t3_handover_gnt", 32'(gnt), 32'h2);
        checkOutput("t3_handover_adr", s_adr, 32'h80);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (m1_ack) got = 1'b1;
            else tick();
        end
        checkOutput("t3_m1_ack_seen", 32'(got), 32'h1);
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0;
        tick();
        checkOutput("t3_idle_gnt", 32'(gnt), 32'h0);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        tick();
        checkOutput("t3_tie2_gnt", 32'(gnt), 32'h1);
        clear_masters();
        tick();
        tick();
        checkOutput("t3_ack_cnt1", 32'(ack_cnt1), 32'h1);
        checkOutput("t3_m1_ack_while_m0", 32'(m1_seen), 32'h0);

        // 64-beat burst from m1; m0 requests at beat 10 and must wait.
        $display("[TB] long burst");
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_cti = 3'b010; m1_adr = 32'h200;
        tick();
        checkOutput("t4_s_cti", 32'(s_cti), 32'h2);
        checkOutput("t4_s_dat_ms", s_dat_ms, 32'h1B1B1B1B);
        beats = 0; bad_gnt = 1'b0; bad_ack = 1'b0;
        for (int k = 0; k < 400 && beats < 64; k++) begin
            if (m0_ack) bad_ack = 1'b1;
            if (gnt != 2'b10) bad_gnt = 1'b1;
            if (m1_ack) begin
                beats++;
                if (beats == 10) begin
                    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h300;
                end
            end
            if (beats < 64) tick();
        end
        checkOutput("t4_beats", 32'(beats), 32'd64);
        checkOutput("t4_gnt_held", 32'(bad_gnt), 32'h0);
        checkOutput("t4_m0_ack_blocked", 32'(bad_ack), 32'h0);
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_cti = 3'b000;
        #1;
        checkOutput("t4_gnt_at_fall", 32'(gnt), 32'h2);
        tick();
        checkOutput("t4_m0_after_burst", 32'(gnt), 32'h1);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (m0_ack) got = 1'b1;
            else tick();
        end
        checkOutput("t4_m0_ack_seen", 32'(got), 32'h1);
        checkOutput("t4_m0_dat", m0_dat_sm, 32'h300);
        tick();
        clear_masters();
        tick();
        checkOutput("t4_ack_cnt1_wrapped", 32'(ack_cnt1), 32'h0);

        // Counter wrap with a 4-bit counter: 17 acks leave it at 1.
        $display("[TB] counter wrap");
        do_reset();
        m1_seen = 1'b0;
        for (int i = 0; i < 17; i++) begin
            m0_read($sformatf("t5_rd%0d", i), 32'h1000 + 32'(i), 1'b0, m1_seen);
            if (i == 14)
                checkOutput("t5_ack_cnt0_15", 32'(ack_cnt0), 32'hF);
        end
        checkOutput("t5_ack_cnt0_wrap", 32'(ack_cnt0), 32'h1);

        // Reset during a granted m1 burst.
        $display("[TB] reset mid-burst");
        do_reset();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_cti = 3'b010; m1_adr = 32'h500;
        tick();
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            if (m1_ack) n++;
            if (n < 3) tick();
        end
        checkOutput("t6_pre_acks", 32'(n), 32'h3);
        checkOutput("t6_pre_gnt", 32'(gnt), 32'h2);
        sys_rst = 1'b1;
        #1;
        checkOutput("t6_rst_s_cyc", 32'(s_cyc), 32'h0);
        checkOutput("t6_rst_gnt", 32'(gnt), 32'h0);
        checkOutput("t6_rst_m1_ack", 32'(m1_ack), 32'h0);
        checkOutput("t6_rst_cnt1", 32'(ack_cnt1), 32'h0);
        tick();
        tick();
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_cti = 3'b000;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h600;
        sys_rst = 1'b0;
        #1;
        checkOutput("t6_release_gnt", 32'(gnt), 32'h0);
        tick();
        checkOutput("t6_m0_granted", 32'(gnt), 32'h1);
        clear_masters();
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wshb_arbiter2.md
# wshb_arbiter2

Two-master, one-slave Wishbone arbiter that shares the SDRAM Wishbone port of `hw_support` between the video-stream reader (master 0) and the frame-buffer writer (master 1). It runs in the `sys_clk` domain, uses round-robin arbitration on `cyc`, and keeps a grant for the whole bus cycle. It also counts acknowledged transfers per master for debug on `LED`/SignalTap.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; `sel` width is `DW/8`.
- `CW`, 16, width of the per-master ack counters.

Ports:
- `sys_clk` in 1: system clock, 100 MHz.
- `sys_rst` in 1: asynchronous, active-high reset.
- `m0_cyc`, `m0_stb`, `m0_we` in 1 each: master 0 (video reader) control.
- `m0_adr` in AW, `m0_dat_ms` in DW, `m0_sel` in DW/8, `m0_cti` in 3, `m0_bte` in 2: master 0 request fields.
- `m0_dat_sm` out DW, `m0_ack` out 1, `m0_err` out 1, `m0_rty` out 1: master 0 response.
- `m1_*`: same set as `m0_*`, for master 1 (frame-buffer writer).
- `s_cyc`, `s_stb`, `s_we` out 1 each, `s_adr` out AW, `s_dat_ms` out DW, `s_sel` out DW/8, `s_cti` out 3, `s_bte` out 2: slave (SDRAM) request.
- `s_dat_sm` in DW, `s_ack` in 1, `s_err` in 1, `s_rty` in 1: slave response.
- `gnt` out 2: one-hot current grant; `2'b00` when idle.
- `ack_cnt0`, `ack_cnt1` out CW: acks delivered to each master, wrapping.

## Operation
State machine, registered:
- **IDLE**
  - Neither `cyc` high: stay in IDLE.
  - Only one `cyc` high: go to that master's GNT state.
  - Both `cyc` high: grant the master that is not `last`.
- **GNT0 / GNT1**
  - Hold while the granted `cyc` is 1.
  - When the granted `cyc` is 0: go to the other GNT state if the other `cyc` is 1, else go to IDLE.
- `last` (1 bit) is set to the granted index on every entry into a GNT state.

Routing (combinational from the state):
- All `s_*` request outputs follow the granted master.
- In IDLE: `s_cyc`, `s_stb` and `s_we` are 0; the other request fields are don't-care but driven from m0.
- `s_cyc` = granted `cyc`. `s_stb` = granted `stb` AND granted `cyc`.
- `s_ack`, `s_err` and `s_rty` reach only the granted master. The non-granted master sees 0 on all three.
- `s_dat_sm` fans out to both `mX_dat_sm` unconditionally.

Grant rules:
- The grant never changes while the granted `cyc` is 1. This covers both classic and burst (`cti`=3'b010) cycles.
- A master that raises `cyc` while not granted waits with no ack. It must hold its request stable (standard Wishbone).

Counters:
- `ack_cntX` increments by 1 on each cycle where `mX_ack` is 1.
- Counters wrap at 2^CW−1 → 0.
- `err` and `rty` are not counted.

## Timing
- Reset values: state IDLE, `last`=1 (so master 0 wins the first tie), `gnt`=0, `ack_cnt0`/`ack_cnt1`=0.
- Because of the outputs above, `s_cyc`=`s_stb`=0 and all `mX_ack`/`err`/`rty`=0 during reset.
- Grant latency is 1 cycle: a `cyc` rising at edge N is forwarded to the slave from edge N+1.
- Handover latency is 1 cycle: if the granted `cyc` falls at edge N, the other master is forwarded from edge N+1. There is no extra idle cycle.
- No added latency on the response path: `ack` and `dat` are combinational pass-through.
- Reset asserted mid-cycle: state returns to IDLE immediately (asynchronous), `s_cyc` drops, and the in-flight transfer is abandoned.
- Simultaneous events:
  - Both `cyc` rise in the same cycle from IDLE: round-robin on `last`.
  - The granted `cyc` falls in the same cycle another `cyc` rises: the other master is granted.
  - Both fall in the same cycle: go to IDLE.

## Test plan
1. **Reset check.** Assert `sys_rst`, release, hold both `cyc` at 0 → `gnt`=00, `s_cyc`=0, counters 0.
2. **Single master.** m0 issues 8 single reads; slave acks 1 cycle after `stb` with `dat` = `adr`. Require:
   - `gnt`=01 one cycle after `m0_cyc`.
   - Each `m0_dat_sm` equals the address.
   - `ack_cnt0`=8, `m1_ack` never 1.
3. **Tie and alternation.** Both `cyc` rise together from reset → m0 is granted. m0 drops `cyc` after 4 acks → m1 is granted the next cycle. A second tie then goes to m0, because `last`=1 after m1.
4. **Long burst not preempted.** m1 runs a 64-beat burst (`cti`=010). m0 requests at beat 10. Require:
   - `gnt` stays 10 until `m1_cyc` falls.
   - `m0_ack`=0 throughout the burst.
   - m0 is granted 1 cycle after the burst ends.
5. **Counter wrap.** With CW=4, deliver 17 acks to m0 → `ack_cnt0`=1.
6. **Reset mid-operation.** Assert `sys_rst` during a granted m1 burst. Require:
   - `s_cyc`=0 and `gnt`=00 in the same cycle.
   - After release with only `m0_cyc`=1, m0 is granted.
